round_sat_stream: RTL and testbench

Multi-channel, run-time-configurable rounding and saturation stage with a valid/ready stream interface. It drops `FRAC_WIDTH = DATA_WIDTH_IN - DATA_WIDTH_OUT` LSBs from each signed channel using a selectable rounding mode. It clamps the result to the signed output range and reports per-channel saturation flags plus a sticky saturation event counter. It sits between accumulator/filter outputs and narrower downstream datapaths, replacing fixed single-channel half-even rounders wherever backpressure or mode selection is needed.

---
 rtl/round_sat_stream.sv | 73 +++++++
 tb/tb_round_sat_stream.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/round_sat_stream.sv
// round_sat_stream: multi-channel rounding/saturation stage with valid/ready handshake
// Ports: clk, rst_n (async, active low); mode selects floor/half-up/half-even/half-away;
// in_valid/in_ready/din input beat; out_valid/out_ready/dout/sat_flag registered output beat;
// clr_cnt clears sat_cnt, the saturating count of accepted beats with any channel clamped.
module round_sat_stream #(
  parameter int DATA_WIDTH_IN  = 16,
  parameter int DATA_WIDTH_OUT = 8,
  parameter int NUM_CH         = 1,
  parameter int SAT_CNT_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [1:0]                         mode,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_CH*DATA_WIDTH_IN-1:0]    din,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_CH*DATA_WIDTH_OUT-1:0]   dout,
  output logic [NUM_CH-1:0]                  sat_flag,
  input  logic                               clr_cnt,
  output logic [SAT_CNT_WIDTH-1:0]           sat_cnt
);
  localparam int W = DATA_WIDTH_IN;
  localparam int O = DATA_WIDTH_OUT;
  localparam int F = W - O;
  localparam logic [O-1:0] MAXV = ~(O'(1) << (O-1));
  logic [NUM_CH*O-1:0] dout_nx;
  logic [NUM_CH-1:0] sat_nx;
  logic acc;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    if (F == 0) begin : g_pass
      assign dout_nx[c*O +: O] = din[c*W +: W];
      assign sat_nx[c] = 1'b0;
    end else begin : g_rnd
      localparam logic [F-1:0] H = F'(1) << (F-1);
      logic [O-1:0] q;
      logic [F-1:0] f;
      logic inc;
      logic [O:0] sum;
      always_comb begin
        q = din[c*W+F +: O];
        f = din[c*W +: F];
        inc = mode == 2'b00 ? 1'b0 :
              mode == 2'b01 ? f >= H :
              mode == 2'b10 ? (f > H || (f == H && q[0])) :
                              (f > H || (f == H && !q[O-1]));
        sum = {q[O-1], q} + (O+1)'(inc);
      end
      // q already fits the output range, so only q == MAXV with inc can overflow
      assign sat_nx[c] = !sum[O] && sum[O-1];
      assign dout_nx[c*O +: O] = sat_nx[c] ? MAXV : sum[O-1:0];
    end
  end
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sat_flag  <= '0;
      sat_cnt   <= '0;
    end else begin
      out_valid <= acc || (out_valid && !out_ready);
      if (acc) begin
        dout     <= dout_nx;
        sat_flag <= sat_nx;
      end
      sat_cnt <= clr_cnt ? '0 :
                 (acc && |sat_nx && !(&sat_cnt)) ? sat_cnt + SAT_CNT_WIDTH'(1) : sat_cnt;
    end
  end
endmodule

// File: tb/tb_round_sat_stream.sv
// tb_round_sat_stream: directed plus random checks of round_sat_stream against an arithmetic model
module tb_round_sat_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] mode;
  logic in_valid, out_ready, clr_cnt, in_ready, out_valid, sat_flag;
  logic [7:0] din;
  logic [3:0] dout;
  logic [15:0] sat_cnt;
  logic [1:0] mode4;
  logic in_valid4, out_ready4, clr4, in_ready4, out_valid4;
  logic [31:0] din4;
  logic [15:0] dout4;
  logic [3:0] sat_flag4;
  logic [1:0] sat_cnt4;
  round_sat_stream #(.DATA_WIDTH_IN(8), .DATA_WIDTH_OUT(4), .NUM_CH(1), .SAT_CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .sat_flag(sat_flag), .clr_cnt(clr_cnt), .sat_cnt(sat_cnt));
  round_sat_stream #(.DATA_WIDTH_IN(8), .DATA_WIDTH_OUT(4), .NUM_CH(4), .SAT_CNT_WIDTH(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode4), .in_valid(in_valid4), .in_ready(in_ready4),
    .din(din4), .out_valid(out_valid4), .out_ready(out_ready4), .dout(dout4),
    .sat_flag(sat_flag4), .clr_cnt(clr4), .sat_cnt(sat_cnt4));
  int total = 0;
  int passed = 0;
  int fails = 0;
  logic [4:0] sb[$];
  int cnt_m = 0;
  logic a;
  logic [7:0] ties[3] = '{8'h28, 8'hD8, 8'h18};
  logic [3:0] ties_exp[12] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hD, 4'hE, 4'hE, 4'hD, 4'h1, 4'h2, 4'h2, 4'h2};
  logic [7:0] bp[4] = '{8'h11, 8'h35, 8'h5A, 8'hC7};
  int p;
  logic [15:0] e_d;
  logic [3:0] e_f;
  logic [4:0] r4;
  // value/16 rounded by the mode's rule, then clamped to +7; returns {sat, 4-bit result}
  function automatic logic [4:0] ref1(input logic [7:0] x, input logic [1:0] m);
    int v, fl, rem, r;
    logic s;
    v = int'($signed(x));
    fl = (v >= 0) ? v / 16 : -((-v + 15) / 16);
    rem = v - fl * 16;
    case (m)
      2'd0: r = fl;
      2'd1: r = fl + ((rem >= 8) ? 1 : 0);
      2'd2: r = fl + ((rem > 8 || (rem == 8 && fl % 2 != 0)) ? 1 : 0);
      default: r = fl + ((rem > 8 || (rem == 8 && v >= 0)) ? 1 : 0);
    endcase
    s = r > 7;
    if (s) r = 7;
    return {s, 4'(r)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m,
                       input logic rdy, input logic clr, output logic acc);
    logic rdy_m;
    logic [4:0] r;
    @(negedge clk);
    in_valid = v; din = d; mode = m; out_ready = rdy; clr_cnt = clr;
    #1;
    rdy_m = sb.size() == 0 || rdy;
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(rdy_m));
    chk("sat_cnt", 32'(sat_cnt), 32'(cnt_m));
    if (sb.size() != 0) begin
      chk("dout", 32'(dout), 32'(sb[0][3:0]));
      chk("sat_flag", 32'(sat_flag), 32'(sb[0][4]));
    end
    acc = v && rdy_m;
    r = ref1(d, m);
    if (sb.size() != 0 && rdy) void'(sb.pop_front());
    if (acc) sb.push_back(r);
    if (clr) cnt_m = 0;
    else if (acc && r[4] && cnt_m < 65535) cnt_m++;
  endtask
  initial begin
    in_valid = 0; din = 0; mode = 0; out_ready = 0; clr_cnt = 0;
    in_valid4 = 0; din4 = 0; mode4 = 2'd2; out_ready4 = 1; clr4 = 0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_sat_flag", 32'(sat_flag), 0);
    chk("rst_sat_cnt", 32'(sat_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid4", 32'(out_valid4), 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 3; i++)
      for (int m = 0; m < 4; m++) begin
        drive(1, ties[i], 2'(m), 1, 0, a);
        drive(0, 8'h00, 2'd0, 1, 0, a);
        chk("tie", 32'(dout), 32'(ties_exp[i*4+m]));
      end
    drive(1, 8'h78, 2'd2, 1, 0, a);
    drive(0, 8'h00, 2'd0, 1, 0, a);
    chk("sat_even_dout", 32'(dout), 7);
    chk("sat_even_flag", 32'(sat_flag), 1);
    drive(1, 8'h78, 2'd0, 1, 0, a);
    drive(0, 8'h00, 2'd0, 1, 0, a);
    chk("floor_dout", 32'(dout), 7);
    chk("floor_flag", 32'(sat_flag), 0);
    for (int m = 0; m < 4; m++) begin
      drive(1, 8'h80, 2'(m), 1, 0, a);
      drive(0, 8'h00, 2'd0, 1, 0, a);
      chk("min_dout", 32'(dout), 8);
      chk("min_flag", 32'(sat_flag), 0);
    end
    p = 0;
    for (int c = 0; c < 20 && p < 4; c++) begin
      drive(1, bp[p], 2'd1, (c < 2 || c > 4), 0, a);
      if (a) p++;
    end
    chk("bp_done", 32'(p), 4);
    drive(0, 8'h00, 2'd0, 1, 0, a);
    drive(0, 8'h00, 2'd0, 1, 0, a);
    drive(0, 8'h00, 2'd0, 1, 1, a);
    repeat (3) drive(1, 8'h78, 2'd2, 1, 0, a);
    drive(0, 8'h00, 2'd0, 1, 0, a);
    chk("cnt3", 32'(sat_cnt), 3);
    drive(1, 8'h78, 2'd2, 1, 1, a);
    drive(0, 8'h00, 2'd0, 1, 0, a);
    chk("cnt_clr", 32'(sat_cnt), 0);
    for (int i = 0; i < 400; i++)
      drive(($urandom % 4) != 0, 8'($urandom), 2'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0, a);
    drive(1, 8'h78, 2'd2, 0, 0, a);
    drive(0, 8'h00, 2'd0, 0, 0, a);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_sat_cnt", 32'(sat_cnt), 0);
    chk("mid_rst_dout", 32'(dout), 0);
    sb.delete();
    cnt_m = 0;
    @(negedge clk) rst_n = 1;
    drive(0, 8'h00, 2'd0, 0, 0, a);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid4 = 1; din4 = 32'h00D82878; mode4 = 2'd2;
    @(negedge clk);
    in_valid4 = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      r4 = ref1(din4[k*8 +: 8], 2'd2);
      e_d[k*4 +: 4] = r4[3:0];
      e_f[k] = r4[4];
    end
    chk("mc_out_valid", 32'(out_valid4), 1);
    chk("mc_dout_model", 32'(dout4), 32'(e_d));
    chk("mc_dout", 32'(dout4), 32'h0E27);
    chk("mc_flag_model", 32'(sat_flag4), 32'(e_f));
    chk("mc_flag", 32'(sat_flag4), 32'h1);
    chk("mc_cnt", 32'(sat_cnt4), 1);
    @(negedge clk) in_valid4 = 1;
    repeat (5) @(negedge clk);
    in_valid4 = 0;
    #1;
    chk("cnt_hold", 32'(sat_cnt4), 3);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
